// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets, register
// selector enum and the byte-lane merge used by every writable register.
package mmio_responder_pkg;

    localparam logic [15:0] BASE_HI_DEFAULT = 16'hbfaf;

    localparam logic [15:0] MMIO_SCRATCH = 16'h0000;
    localparam logic [15:0] MMIO_LED     = 16'h0004;
    localparam logic [15:0] MMIO_SWITCH  = 16'h0008;
    localparam logic [15:0] MMIO_TIMER   = 16'h000c;
    localparam logic [15:0] MMIO_COMPARE = 16'h0010;
    localparam logic [15:0] MMIO_STATUS  = 16'h0014;

    typedef enum logic [2:0] {
        REG_SCRATCH,
        REG_LED,
        REG_SWITCH,
        REG_TIMER,
        REG_COMPARE,
        REG_STATUS,
        REG_NONE
    } reg_e;

    // Byte offset with the word-alignment bits forced to zero.
    function automatic reg_e decode_offset(input logic [15:0] offset);
        reg_e r;
        case ({offset[15:2], 2'b00})
            MMIO_SCRATCH: r = REG_SCRATCH;
            MMIO_LED:     r = REG_LED;
            MMIO_SWITCH:  r = REG_SWITCH;
            MMIO_TIMER:   r = REG_TIMER;
            MMIO_COMPARE: r = REG_COMPARE;
            MMIO_STATUS:  r = REG_STATUS;
            default:      r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  wen);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Data-SRAM style request/response port between the core and the MMIO block.
interface mmio_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare match, enable and sticky pending flag.
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_we_i,
    input  logic [31:0] timer_wval_i,
    input  logic        cmp_we_i,
    input  logic [31:0] cmp_wval_i,
    input  logic        en_we_i,
    input  logic        en_wval_i,
    input  logic        pend_clr_i,
    output logic [31:0] timer_o,
    output logic [31:0] compare_o,
    output logic        enable_o,
    output logic        pending_o
);

    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic        enable_q;
    logic        pending_q;
    logic        match;

    assign match = enable_q && (timer_q == compare_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q   <= 32'h0;
            compare_q <= 32'hffff_ffff;
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            timer_q <= timer_we_i ? timer_wval_i : timer_q + 32'd1;
            if (cmp_we_i) compare_q <= cmp_wval_i;
            if (en_we_i)  enable_q  <= en_wval_i;
            // A match on the same edge as a clear keeps the interrupt raised.
            if (match)           pending_q <= 1'b1;
            else if (pend_clr_i) pending_q <= 1'b0;
        end
    end

    assign timer_o   = timer_q;
    assign compare_o = compare_q;
    assign enable_o  = enable_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO window beside data RAM: scratch, LED, synchronised switches and a
// compare timer, with read data registered one cycle after the request.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [15:0] BASE_HI = BASE_HI_DEFAULT,
    parameter int          LED_W   = 16,
    parameter int          SW_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    mmio_responder_if.slave  bus,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led,
    output logic             timer_int
);

    logic        sel;
    logic        wr_en;
    logic        rd_en;
    reg_e        reg_sel;
    logic [3:0]  wen;
    logic [31:0] wdata;

    logic [31:0]      scratch_q, scratch_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rd_val;
    logic [31:0]      led_wval;

    logic [31:0] timer_val, compare_val;
    logic        enable_val, pending_val;
    logic        timer_we, cmp_we, status_we;

    logic unused_bits;

    assign wen     = bus.data_sram_wen;
    assign wdata   = bus.data_sram_wdata;
    assign sel     = bus.data_sram_en && (bus.data_sram_addr[31:16] == BASE_HI);
    assign wr_en   = sel && (wen != 4'b0000);
    assign rd_en   = sel && (wen == 4'b0000);
    assign reg_sel = decode_offset(bus.data_sram_addr[15:0]);

    assign timer_we  = wr_en && (reg_sel == REG_TIMER);
    assign cmp_we    = wr_en && (reg_sel == REG_COMPARE);
    assign status_we = wr_en && (reg_sel == REG_STATUS) && wen[0];

    assign led_wval  = byte_merge(32'(led_q), wdata, wen);
    assign scratch_d = (wr_en && reg_sel == REG_SCRATCH) ? byte_merge(scratch_q, wdata, wen)
                                                         : scratch_q;
    assign led_d     = (wr_en && reg_sel == REG_LED) ? led_wval[LED_W-1:0] : led_q;

    mmio_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .timer_we_i   (timer_we),
        .timer_wval_i (byte_merge(timer_val, wdata, wen)),
        .cmp_we_i     (cmp_we),
        .cmp_wval_i   (byte_merge(compare_val, wdata, wen)),
        .en_we_i      (status_we),
        .en_wval_i    (wdata[1]),
        .pend_clr_i   ((status_we && wdata[0]) || cmp_we),
        .timer_o      (timer_val),
        .compare_o    (compare_val),
        .enable_o     (enable_val),
        .pending_o    (pending_val)
    );

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        rd_val = 32'h0;
        case (reg_sel)
            REG_SCRATCH: rd_val = scratch_q;
            REG_LED:     rd_val = 32'(led_q);
            REG_SWITCH:  rd_val = 32'(sw_sync_q);
            REG_TIMER:   rd_val = timer_val;
            REG_COMPARE: rd_val = compare_val;
            REG_STATUS:  rd_val = {30'h0, enable_val, pending_val};
            default:     rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch_q <= 32'h0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= 32'h0;
        end else begin
            scratch_q <= scratch_d;
            led_q     <= led_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            // rdata holds its value across writes and unselected requests.
            if (rd_en) rdata_q <= rd_val;
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
    assign timer_int           = pending_val;

    // Word-alignment address bits and the LED merge bits above LED_W are don't-cares.
    assign unused_bits = ^{bus.data_sram_addr[1:0], led_wval};

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: reads push expected data to a scoreboard
// queue, which is popped and compared when the registered response appears.
module tb_mmio_responder;
    import mmio_responder_pkg::*;

    localparam logic [31:0] A_SCRATCH = 32'hbfaf_0000;
    localparam logic [31:0] A_LED     = 32'hbfaf_0004;
    localparam logic [31:0] A_SWITCH  = 32'hbfaf_0008;
    localparam logic [31:0] A_TIMER   = 32'hbfaf_000c;
    localparam logic [31:0] A_COMPARE = 32'hbfaf_0010;
    localparam logic [31:0] A_STATUS  = 32'hbfaf_0014;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic [15:0] led;
    logic        timer_int;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_responder_if bus ();

    mmio_responder #(
        .BASE_HI (16'hbfaf),
        .LED_W   (16),
        .SW_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switch    (sw),
        .led       (led),
        .timer_int (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors_applied++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one edge, then compare any response that was due on it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check(tag_q.pop_front(), bus.data_sram_rdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = data;
        tick();
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = 32'h0;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        tick();
        bus.data_sram_en    = 1'b0;
    endtask

    initial begin
        rst                 = 1'b0;
        sw                  = 8'h00;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        check("rst_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_int", {31'h0, timer_int}, 32'h0);
        rd("rst_compare", A_COMPARE, 32'hffff_ffff);
        rd("rst_status", A_STATUS, 32'h0);

        // Byte-lane merge into SCRATCH
        wr(A_SCRATCH, 4'b0101, 32'h1234_5678);
        rd("scratch_merge", A_SCRATCH, 32'h0034_0078);
        wr(A_SCRATCH, 4'b1000, 32'hab00_0000);
        rd("scratch_merge2", A_SCRATCH, 32'hab34_0078);

        // TIMER counting: write 0x10, three idle edges, then back-to-back reads
        wr(A_TIMER, 4'hf, 32'h0000_0010);
        tick(); tick(); tick();
        rd("timer_rd0", A_TIMER, 32'h13);
        rd("timer_rd1", A_TIMER, 32'h14);
        rd("timer_rd2", A_TIMER, 32'h15);

        // Wrap from all-ones to zero
        wr(A_TIMER, 4'hf, 32'hffff_fffe);
        tick(); tick();
        rd("timer_wrap", A_TIMER, 32'h0);

        // Compare interrupt: match when the pre-edge TIMER equals COMPARE
        wr(A_COMPARE, 4'hf, 32'h20);
        wr(A_STATUS, 4'b0001, 32'h2);
        wr(A_TIMER, 4'hf, 32'h1e);
        tick(); check("int_pre1", {31'h0, timer_int}, 32'h0);
        tick(); check("int_pre2", {31'h0, timer_int}, 32'h0);
        tick(); check("int_rise", {31'h0, timer_int}, 32'h1);
        rd("status_pend", A_STATUS, 32'h3);
        wr(A_STATUS, 4'b0001, 32'h3);
        check("int_w1c", {31'h0, timer_int}, 32'h0);
        rd("status_en", A_STATUS, 32'h2);

        // Match on the same edge as a W1C clear: set wins
        wr(A_COMPARE, 4'hf, 32'h100);
        wr(A_TIMER, 4'hf, 32'hfe);
        tick(); tick();
        check("int_before", {31'h0, timer_int}, 32'h0);
        wr(A_STATUS, 4'b0001, 32'h3);
        check("int_set_wins", {31'h0, timer_int}, 32'h1);
        tick();
        check("int_sticky", {31'h0, timer_int}, 32'h1);
        wr(A_COMPARE, 4'hf, 32'hffff_0000);
        check("int_cmp_clr", {31'h0, timer_int}, 32'h0);

        // Undefined offset, switch synchroniser, ignored switch write, unselected read
        rd("undef_rd", 32'hbfaf_0100, 32'h0);
        sw = 8'ha5;
        tick(); tick();
        rd("switch_rd", A_SWITCH, 32'h0000_00a5);
        wr(A_SWITCH, 4'hf, 32'h0);
        rd("switch_ro", A_SWITCH, 32'h0000_00a5);
        rd("unsel_hold", 32'h8000_0008, 32'h0000_00a5);

        // LED register and output
        wr(A_LED, 4'b0011, 32'hdead_beef);
        check("led_out", 32'(led), 32'h0000_beef);
        rd("led_rd", A_LED, 32'h0000_beef);

        // Asynchronous reset mid-count, with a request in flight
        #2;
        rst = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_int", {31'h0, timer_int}, 32'h0);
        check("arst_rdata", bus.data_sram_rdata, 32'h0);
        bus.data_sram_en   = 1'b1;
        bus.data_sram_wen  = 4'b0000;
        bus.data_sram_addr = A_SCRATCH;
        @(posedge clk);
        #1;
        rst              = 1'b1;
        bus.data_sram_en = 1'b0;
        tick();
        check("arst_no_resp", bus.data_sram_rdata, 32'h0);
        rd("arst_compare", A_COMPARE, 32'hffff_ffff);
        rd("arst_scratch", A_SCRATCH, 32'h0);
        rd("arst_status", A_STATUS, 32'h0);
        check("arst_int_after", {31'h0, timer_int}, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
